// File: rtl/turn_signal_scheduler.sv
// Arbitrates left/right/hazard switches onto a single shared taillight sequencer,
// issuing one-cycle request pulses and guaranteeing comfort-blink repeats after a short tap.
module turn_signal_scheduler #(
  parameter int DEB_CYCLES  = 4,
  parameter int COMFORT_SEQ = 3,
  parameter int CNT_W       = 3
) (
  input  logic       div_clk,
  input  logic       rst,
  input  logic       left_sw,
  input  logic       right_sw,
  input  logic       hazard_sw,
  input  logic       seq_idle,
  output logic       seq_left,
  output logic       seq_right,
  output logic [1:0] active_side,
  output logic       hazard_act,
  output logic       seq_err
);

  localparam int DW = $clog2(DEB_CYCLES);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [1:0] SIDE_NONE = 2'b00;
  localparam logic [1:0] SIDE_L    = 2'b01;
  localparam logic [1:0] SIDE_R    = 2'b10;

  localparam logic [DW-1:0]    DEB_LAST     = DW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0]    DEB_ONE      = DW'(1);
  localparam logic [DW-1:0]    DEB_ZERO     = DW'(0);
  localparam logic [CNT_W-1:0] COMFORT_LOAD = CNT_W'(COMFORT_SEQ);
  localparam logic [CNT_W-1:0] REM_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] REM_ZERO     = CNT_W'(0);

  // Bit order for the per-switch vectors: [0] left, [1] right, [2] hazard.
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_lvl;
  logic [1:0]       r_lvl_prev;
  logic [DW-1:0]    r_deb_cnt [3];
  logic [1:0]       w_rise;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_seq_left;
  logic             r_seq_right;
  logic [1:0]       r_active_side;
  logic             r_hazard_act;
  logic             r_seq_err;
  logic             r_rr_right;
  logic             r_run_first;

  logic [CNT_W-1:0] r_remain;
  logic [1:0]       r_comf_side;

  logic             w_grant;
  logic [1:0]       w_grant_side;
  logic             w_grant_haz;
  logic             w_done;
  logic             w_abort;

  // Synchronize the raw switches and debounce each synchronized level.
  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 3'b000;
      r_sync2    <= 3'b000;
      r_lvl      <= 3'b000;
      r_lvl_prev <= 2'b00;
      for (int i = 0; i < 3; i++) begin
        r_deb_cnt[i] <= DEB_ZERO;
      end
    end else begin
      r_sync1    <= {hazard_sw, right_sw, left_sw};
      r_sync2    <= r_sync1;
      r_lvl_prev <= r_lvl[1:0];
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_lvl[i]) begin
          r_deb_cnt[i] <= DEB_ZERO;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_lvl[i]     <= r_sync2[i];
          r_deb_cnt[i] <= DEB_ZERO;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DEB_ONE;
        end
      end
    end
  end

  assign w_rise = r_lvl[1:0] & ~r_lvl_prev;

  // Arbitration and next-state decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    w_grant_side = SIDE_NONE;
    w_grant_haz  = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (seq_idle) begin
          if (r_lvl[2]) begin
            w_grant      = 1'b1;
            w_grant_haz  = 1'b1;
            w_grant_side = r_rr_right ? SIDE_L : SIDE_R;
          end else if (r_lvl[0] ^ r_lvl[1]) begin
            w_grant      = 1'b1;
            w_grant_side = r_lvl[0] ? SIDE_L : SIDE_R;
          end else if (!(r_lvl[0] & r_lvl[1]) && (r_remain != REM_ZERO) &&
                       (r_comf_side != SIDE_NONE)) begin
            w_grant      = 1'b1;
            w_grant_side = r_comf_side;
          end else begin
            w_grant = 1'b0;
          end
        end else begin
          w_grant = 1'b0;
        end
        if (w_grant) begin
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // Still idle one cycle after the pulse means the sequencer never took it.
        if (seq_idle && r_run_first) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (seq_idle) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, request pulses, grant status and the hazard round-robin pointer.
  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_seq_left    <= 1'b0;
      r_seq_right   <= 1'b0;
      r_active_side <= SIDE_NONE;
      r_hazard_act  <= 1'b0;
      r_seq_err     <= 1'b0;
      r_rr_right    <= 1'b1;
      r_run_first   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_seq_left  <= 1'b0;
      r_seq_right <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_seq_left    <= (w_grant_side == SIDE_L);
            r_seq_right   <= (w_grant_side == SIDE_R);
            r_active_side <= w_grant_side;
            r_hazard_act  <= w_grant_haz;
            if (w_grant_haz) begin
              r_rr_right <= (w_grant_side == SIDE_R);
            end
          end
        end
        ST_ISSUE: begin
          r_run_first <= 1'b1;
        end
        ST_RUN: begin
          r_run_first <= 1'b0;
          if (w_abort) begin
            r_seq_err <= 1'b1;
          end
          if (w_abort || w_done) begin
            r_active_side <= SIDE_NONE;
            r_hazard_act  <= 1'b0;
          end
        end
        default: begin
          r_active_side <= SIDE_NONE;
          r_hazard_act  <= 1'b0;
          r_run_first   <= 1'b0;
        end
      endcase
    end
  end

  // Comfort-blink budget: loaded by a clean tap, cleared by hazard, spent per completed sequence.
  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      r_remain    <= REM_ZERO;
      r_comf_side <= SIDE_NONE;
    end else if (r_lvl[2]) begin
      r_remain <= REM_ZERO;
    end else if (w_rise[0] && !r_lvl[1]) begin
      r_remain    <= COMFORT_LOAD;
      r_comf_side <= SIDE_L;
    end else if (w_rise[1] && !r_lvl[0]) begin
      r_remain    <= COMFORT_LOAD;
      r_comf_side <= SIDE_R;
    end else if (w_done && (r_active_side == r_comf_side) && (r_remain != REM_ZERO)) begin
      r_remain <= r_remain - REM_ONE;
    end
  end

  assign seq_left    = r_seq_left;
  assign seq_right   = r_seq_right;
  assign active_side = r_active_side;
  assign hazard_act  = r_hazard_act;
  assign seq_err     = r_seq_err;

endmodule

// File: tb/tb_turn_signal_scheduler.sv
// Scoreboard bench for turn_signal_scheduler with an attached S0/L1-L3/R1-R3 sequencer model;
// expected request pulses (side, hazard flag, cycle) are queued by stimulus and popped by a monitor.
module tb_turn_signal_scheduler;

  localparam logic [1:0] SD_L = 2'b01;
  localparam logic [1:0] SD_R = 2'b10;

  logic       div_clk;
  logic       rst;
  logic       left_sw;
  logic       right_sw;
  logic       hazard_sw;
  logic       seq_idle;
  logic       seq_left;
  logic       seq_right;
  logic [1:0] active_side;
  logic       hazard_act;
  logic       seq_err;

  logic [2:0] sq_st;
  logic       tie_idle;
  logic [5:0] w_outs;

  typedef struct {
    logic [1:0] side;
    logic       haz;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   t0;
  bit   mon_en;

  turn_signal_scheduler #(
    .DEB_CYCLES (4),
    .COMFORT_SEQ(3),
    .CNT_W      (3)
  ) dut (
    .div_clk    (div_clk),
    .rst        (rst),
    .left_sw    (left_sw),
    .right_sw   (right_sw),
    .hazard_sw  (hazard_sw),
    .seq_idle   (seq_idle),
    .seq_left   (seq_left),
    .seq_right  (seq_right),
    .active_side(active_side),
    .hazard_act (hazard_act),
    .seq_err    (seq_err)
  );

  assign w_outs   = {seq_left, seq_right, active_side, hazard_act, seq_err};
  assign seq_idle = (sq_st == 3'd0) || tie_idle;

  initial begin
    div_clk = 1'b0;
    forever #5 div_clk = ~div_clk;
  end

  always @(posedge div_clk) cyc <= cyc + 1;

  // Sequencer model: S0=0, L1..L3=1..3, R1..R3=4..6.
  always @(posedge div_clk or posedge rst) begin
    if (rst) sq_st <= 3'd0;
    else begin
      case (sq_st)
        3'd0: if (seq_left) sq_st <= 3'd1; else if (seq_right) sq_st <= 3'd4;
        3'd1: sq_st <= 3'd2;
        3'd2: sq_st <= 3'd3;
        3'd4: sq_st <= 3'd5;
        3'd5: sq_st <= 3'd6;
        default: sq_st <= 3'd0;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, got, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] side, input logic haz, input int c);
    exp_t e;
    e.side = side;
    e.haz  = haz;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge div_clk);
    check("missed_pulses", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: every request pulse must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge div_clk);
      if (mon_en && !rst && (seq_left || seq_right)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'({seq_right, seq_left}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle", 32'(cyc), 32'(e.cyc));
          check("pulse_side", 32'({seq_right, seq_left}), 32'(e.side));
          check("active_side", 32'(active_side), 32'(e.side));
          check("hazard_act", 32'(hazard_act), 32'(e.haz));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; left_sw = 1'b0; right_sw = 1'b0; hazard_sw = 1'b0;
    tie_idle = 1'b0; mon_en = 1'b1;
    #1;
    check("reset_state", 32'(w_outs), 32'd0);

    // 1: reset held with switches toggling, then a left tap after release
    for (int i = 0; i < 10; i++) begin
      @(negedge div_clk);
      {hazard_sw, right_sw, left_sw} = 3'($urandom_range(0, 7));
      check("outputs_in_reset", 32'(w_outs), 32'd0);
    end
    @(negedge div_clk);
    t0 = cyc;
    for (int k = 0; k < 3; k++) push_exp(SD_L, 1'b0, t0 + 7 + 6 * k);
    left_sw = 1'b1; right_sw = 1'b0; hazard_sw = 1'b0; rst = 1'b0;
    repeat (8) @(negedge div_clk);
    left_sw = 1'b0;
    settle(30);

    // 2: left tap of 8 cycles -> 3 comfort pulses; 3-cycle glitch -> none
    t0 = cyc;
    for (int k = 0; k < 3; k++) push_exp(SD_L, 1'b0, t0 + 7 + 6 * k);
    left_sw = 1'b1;
    repeat (8) @(negedge div_clk);
    left_sw = 1'b0;
    settle(30);
    left_sw = 1'b1;
    repeat (3) @(negedge div_clk);
    left_sw = 1'b0;
    settle(25);

    // 3: right held 40 cycles -> pulse every 6 cycles, none after release
    t0 = cyc;
    for (int k = 0; k < 7; k++) push_exp(SD_R, 1'b0, t0 + 7 + 6 * k);
    right_sw = 1'b1;
    repeat (40) @(negedge div_clk);
    right_sw = 1'b0;
    settle(30);

    // 4: hazard held 30 cycles -> L,R,L,R,L with hazard_act; left press ignored
    t0 = cyc;
    for (int k = 0; k < 5; k++) push_exp((k % 2 == 0) ? SD_L : SD_R, 1'b1, t0 + 7 + 6 * k);
    hazard_sw = 1'b1;
    repeat (10) @(negedge div_clk);
    left_sw = 1'b1;
    repeat (10) @(negedge div_clk);
    left_sw = 1'b0;
    repeat (10) @(negedge div_clk);
    hazard_sw = 1'b0;
    settle(30);

    // 5a: left and right both held -> no grant
    left_sw = 1'b1; right_sw = 1'b1;
    repeat (20) @(negedge div_clk);
    left_sw = 1'b0; right_sw = 1'b0;
    settle(30);

    // 5b: sequencer never leaves S0 -> seq_err after first ISSUE, sticky
    mon_en = 1'b0; tie_idle = 1'b1;
    t0 = cyc;
    left_sw = 1'b1;
    repeat (8) @(negedge div_clk);
    check("seq_err_before_run", 32'(seq_err), 32'd0);
    left_sw = 1'b0;
    @(negedge div_clk);
    check("seq_err_set", 32'(seq_err), 32'd1);
    repeat (20) @(negedge div_clk);
    check("seq_err_sticky", 32'(seq_err), 32'd1);
    rst = 1'b1;
    #1;
    check("seq_err_cleared_by_rst", 32'(w_outs), 32'd0);
    repeat (3) @(negedge div_clk);
    tie_idle = 1'b0; rst = 1'b0;
    repeat (5) @(negedge div_clk);
    mon_en = 1'b1;

    // 6: reset during RUN of the 2nd comfort sequence -> outputs 0 at once, nothing reissued
    t0 = cyc;
    push_exp(SD_L, 1'b0, t0 + 7);
    push_exp(SD_L, 1'b0, t0 + 13);
    left_sw = 1'b1;
    repeat (8) @(negedge div_clk);
    left_sw = 1'b0;
    repeat (7) @(negedge div_clk);
    check("active_side_in_run", 32'(active_side), 32'(SD_L));
    rst = 1'b1;
    #1;
    check("outputs_at_rst", 32'(w_outs), 32'd0);
    repeat (3) @(negedge div_clk);
    rst = 1'b0;
    settle(40);
    check("outputs_after_rst", 32'(w_outs), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
